// File: rtl/jogo_pkg.sv
// jogo_pkg -- shared encodings for the memory-game round controller.
//   estado_t : FSM state encoding (also exported on db_estado)
//   fase_t   : round phase, showing the sequence or playing it back
//   NIVEL_*  : values of the nivel input (short / full-length round)
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        LE_MEM      = 4'd2,
        MOSTRA_ON   = 4'd3,
        MOSTRA_OFF  = 4'd4,
        ESPERA      = 4'd5,
        REGISTRA    = 4'd6,
        COMPARA     = 4'd7,
        PROXIMA     = 4'd8,
        PISCA_ON    = 4'd9,
        PISCA_OFF   = 4'd10,
        FIM_ACERTO  = 4'd11,
        FIM_ERRO    = 4'd12,
        FIM_TIMEOUT = 4'd13
    } estado_t;

    typedef enum logic {
        FASE_MOSTRA = 1'b0,
        FASE_JOGA   = 1'b1
    } fase_t;

    localparam logic NIVEL_FACIL   = 1'b0;  // round length DEPTH/2
    localparam logic NIVEL_DIFICIL = 1'b1;  // round length DEPTH

endpackage

// File: rtl/contador_m.sv
// contador_m -- free-running modulo-MAX counter used for every timer in the
// round controller (LED on/off timing, play timeout, blink count).
// Ports:
//   clock  : system clock
//   reset  : synchronous active-high reset, count -> 0
//   clear  : synchronous clear, count -> 0 (same priority as reset)
//   enable : advance by one; wraps from MAX-1 back to 0
//   count  : current value, 0..MAX-1
module contador_m #(
    parameter int MAX = 4,
    localparam int W = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == W'(MAX - 1)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jogo_rodada_param.sv
// jogo_rodada_param -- one round of a "repeat the sequence" game.
// The controller shows a sequence read from an external ROM on the LEDs,
// then waits for the player to repeat it on the buttons, one position at a
// time. A full correct round ends with N_BLINK all-on blinks.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   iniciar      : start a round (only in INICIAL or any FIM_* state)
//   nivel        : round length select, latched when a round starts
//   botoes       : raw buttons; a play is a rising edge of their OR
//   mem_addr     : sequence ROM address
//   mem_data     : ROM data, one cycle of latency after mem_addr
//   leds         : LED drive
//   acertos      : saturating count of rounds won
//   pronto       : round finished (any FIM_* state)
//   ganhou       : round won; timeout : round lost by timeout
//   db_estado    : current FSM state; db_jogada : last registered play
module jogo_rodada_param
    import jogo_pkg::*;
#(
    parameter int N         = 4,
    parameter int DEPTH     = 16,
    parameter int T_ON      = 500,
    parameter int T_OFF     = 500,
    parameter int T_TIMEOUT = 300000,
    parameter int N_BLINK   = 3,
    parameter int HITS_MAX  = 3,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int HW       = $clog2(HITS_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              nivel,
    input  logic [N-1:0]      botoes,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_data,
    output logic [N-1:0]      leds,
    output logic [HW-1:0]     acertos,
    output logic              pronto,
    output logic              ganhou,
    output logic              timeout,
    output logic [3:0]        db_estado,
    output logic [N-1:0]      db_jogada
);

    // Timer widths mirror the width rule inside contador_m.
    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int OW   = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;
    localparam int BW   = (N_BLINK > 1) ? $clog2(N_BLINK) : 1;

    estado_t           state, stateNext;
    fase_t             phase;
    logic              nivelLat;
    logic              prevOr;
    logic              playEvt;
    logic [ADDR_W-1:0] lastAddr;
    logic [TW-1:0]     tmrCount;
    logic [OW-1:0]     tmoCount;
    logic [BW-1:0]     blkCount;
    logic              onDone, offDone, tmoDone, blkDone;
    logic              isLast, isCorrect;

    // The on/off timer restarts on every state change, so its count is the
    // number of cycles already spent in the current state.
    contador_m #(.MAX(TMAX)) tmr (
        .clock  (clock),
        .reset  (reset),
        .clear  (stateNext != state),
        .enable (1'b1),
        .count  (tmrCount)
    );

    // Timeout counter is held at zero outside ESPERA, so it starts at 0 on entry.
    contador_m #(.MAX(T_TIMEOUT)) tmo (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != ESPERA),
        .enable (1'b1),
        .count  (tmoCount)
    );

    // Counts completed on/off blink pairs of the win display.
    contador_m #(.MAX(N_BLINK)) blk (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == COMPARA),
        .enable ((state == PISCA_OFF) && offDone),
        .count  (blkCount)
    );

    assign onDone    = (tmrCount == TW'(T_ON - 1));
    assign offDone   = (tmrCount == TW'(T_OFF - 1));
    assign tmoDone   = (tmoCount == OW'(T_TIMEOUT - 1));
    assign blkDone   = (blkCount == BW'(N_BLINK - 1));
    assign lastAddr  = (nivelLat == NIVEL_DIFICIL) ? ADDR_W'(DEPTH - 1) : ADDR_W'(DEPTH / 2 - 1);
    assign isLast    = (mem_addr == lastAddr);
    assign isCorrect = (db_jogada == mem_data);

    // Edge detector history runs every cycle, so a button already held when
    // ESPERA is entered never counts as a new play.
    assign playEvt = (|botoes) && !prevOr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INICIAL;
            phase     <= FASE_MOSTRA;
            nivelLat  <= NIVEL_FACIL;
            mem_addr  <= '0;
            db_jogada <= '0;
            acertos   <= '0;
            prevOr    <= 1'b0;
        end else begin
            state  <= stateNext;
            prevOr <= |botoes;
            case (state)
                INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        nivelLat  <= nivel;
                        mem_addr  <= '0;
                        db_jogada <= '0;
                        phase     <= FASE_MOSTRA;
                    end
                end
                MOSTRA_OFF: begin
                    if (offDone) begin
                        if (isLast) begin
                            phase    <= FASE_JOGA;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                REGISTRA: db_jogada <= botoes;
                COMPARA: begin
                    if (isCorrect && isLast && (acertos != HW'(HITS_MAX))) begin
                        acertos <= acertos + 1'b1;
                    end
                end
                PROXIMA: mem_addr <= mem_addr + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                if (iniciar) stateNext = PREPARA;
            PREPARA:    stateNext = LE_MEM;
            LE_MEM:     stateNext = (phase == FASE_MOSTRA) ? MOSTRA_ON : ESPERA;
            MOSTRA_ON:  if (onDone) stateNext = MOSTRA_OFF;
            MOSTRA_OFF: if (offDone) stateNext = LE_MEM;
            ESPERA: begin
                // A play in the expiry cycle is still accepted.
                if (playEvt)      stateNext = REGISTRA;
                else if (tmoDone) stateNext = FIM_TIMEOUT;
            end
            REGISTRA:   stateNext = COMPARA;
            COMPARA: begin
                if (!isCorrect)  stateNext = FIM_ERRO;
                else if (isLast) stateNext = PISCA_ON;
                else             stateNext = PROXIMA;
            end
            PROXIMA:    stateNext = LE_MEM;
            PISCA_ON:   if (onDone) stateNext = PISCA_OFF;
            PISCA_OFF:  if (offDone) stateNext = blkDone ? FIM_ACERTO : PISCA_ON;
            default:    stateNext = INICIAL;
        endcase
    end

    always_comb begin
        leds = '0;
        if (state == MOSTRA_ON)     leds = mem_data;
        else if (state == PISCA_ON) leds = '1;
    end

    assign pronto    = (state == FIM_ACERTO) || (state == FIM_ERRO) || (state == FIM_TIMEOUT);
    assign ganhou    = (state == FIM_ACERTO);
    assign timeout   = (state == FIM_TIMEOUT);
    assign db_estado = state;

endmodule

// File: tb/tb_jogo_rodada_param.sv
// tb_jogo_rodada_param -- directed bench for jogo_rodada_param with
// N=4, DEPTH=4, T_ON=T_OFF=4, T_TIMEOUT=20, N_BLINK=2, HITS_MAX=3 and a
// registered sequence ROM holding {1,2,4,8}.
module tb_jogo_rodada_param;
    import jogo_pkg::*;

    logic       clock = 1'b0;
    logic       reset, iniciar, nivel;
    logic [3:0] botoes;
    logic [1:0] mem_addr;
    logic [3:0] mem_data;
    logic [3:0] leds;
    logic [1:0] acertos;
    logic       pronto, ganhou, timeout;
    logic [3:0] db_estado, db_jogada;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    always #5 clock = ~clock;

    // One cycle of ROM read latency.
    always @(posedge clock) mem_data <= rom[mem_addr];

    jogo_rodada_param #(
        .N(4), .DEPTH(4), .T_ON(4), .T_OFF(4),
        .T_TIMEOUT(20), .N_BLINK(2), .HITS_MAX(3)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .nivel(nivel),
        .botoes(botoes), .mem_addr(mem_addr), .mem_data(mem_data),
        .leds(leds), .acertos(acertos), .pronto(pronto), .ganhou(ganhou),
        .timeout(timeout), .db_estado(db_estado), .db_jogada(db_jogada)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic holdChk(input string tag, input int n, input logic [3:0] st, input logic [3:0] ld);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_state"}, db_estado, st);
            chk({tag, "_leds"}, leds, ld);
            step();
        end
    endtask

    // Starts a round and follows the whole show; ends observing ESPERA.
    task automatic startShow(input logic nv, input int len);
        nivel   = nv;
        iniciar = 1'b1;
        step();
        chk("prepara_state", db_estado, PREPARA);
        chk("prepara_addr", mem_addr, 2'd0);
        chk("prepara_jogada", db_jogada, 4'd0);
        iniciar = 1'b0;
        step();
        chk("le_mem_state", db_estado, LE_MEM);
        for (int p = 0; p < len; p++) begin
            step();
            holdChk("show_on", 4, MOSTRA_ON, rom[p]);
            holdChk("show_off", 4, MOSTRA_OFF, 4'h0);
            chk("show_le_mem", db_estado, LE_MEM);
        end
        step();
        chk("espera_entry", db_estado, ESPERA);
        chk("espera_addr0", mem_addr, 2'd0);
    endtask

    // Presses b from ESPERA; ends observing the state after COMPARA.
    task automatic play(input logic [3:0] b);
        botoes = b;
        step();
        chk("registra_state", db_estado, REGISTRA);
        step();
        chk("compara_state", db_estado, COMPARA);
        chk("compara_jogada", db_jogada, b);
        botoes = 4'h0;
        step();
    endtask

    task automatic playOk(input logic [3:0] b, input logic last);
        play(b);
        if (last) begin
            chk("win_pisca", db_estado, PISCA_ON);
        end else begin
            chk("next_proxima", db_estado, PROXIMA);
            step();
            step();
            chk("next_espera", db_estado, ESPERA);
        end
    endtask

    task automatic blink();
        for (int k = 0; k < 2; k++) begin
            holdChk("blink_on", 4, PISCA_ON, 4'hF);
            holdChk("blink_off", 4, PISCA_OFF, 4'h0);
        end
        chk("fim_acerto_state", db_estado, FIM_ACERTO);
        chk("fim_acerto_ganhou", ganhou, 1'b1);
        chk("fim_acerto_pronto", pronto, 1'b1);
        chk("fim_acerto_timeout", timeout, 1'b0);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; nivel = 1'b0; botoes = 4'h0;
        step();
        step();
        reset = 1'b0;
        chk("rst_state", db_estado, INICIAL);
        chk("rst_leds", leds, 4'h0);
        chk("rst_acertos", acertos, 2'd0);
        chk("rst_jogada", db_jogada, 4'h0);
        chk("rst_addr", mem_addr, 2'd0);
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_ganhou", ganhou, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        step();
        chk("idle_state", db_estado, INICIAL);

        // Short round won: plays 1, 2.
        startShow(1'b0, 2);
        playOk(4'h1, 1'b0);
        playOk(4'h2, 1'b1);
        chk("win1_acertos", acertos, 2'd1);
        blink();
        chk("win1_acertos_end", acertos, 2'd1);

        // Full round lost at third play.
        startShow(1'b1, 4);
        playOk(4'h1, 1'b0);
        playOk(4'h2, 1'b0);
        play(4'h8);
        chk("erro_state", db_estado, FIM_ERRO);
        chk("erro_pronto", pronto, 1'b1);
        chk("erro_ganhou", ganhou, 1'b0);
        chk("erro_timeout", timeout, 1'b0);
        chk("erro_jogada", db_jogada, 4'h8);
        chk("erro_acertos", acertos, 2'd1);
        chk("erro_leds", leds, 4'h0);

        // No play: timeout exactly 20 cycles after ESPERA entry.
        startShow(1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            chk("tmo_wait", db_estado, ESPERA);
            step();
        end
        chk("tmo_state", db_estado, FIM_TIMEOUT);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_pronto", pronto, 1'b1);
        chk("tmo_ganhou", ganhou, 1'b0);

        // Play edge in the 20th cycle wins over the timeout.
        startShow(1'b0, 2);
        for (int i = 0; i < 19; i++) step();
        chk("late_still_espera", db_estado, ESPERA);
        playOk(4'h1, 1'b0);
        playOk(4'h2, 1'b1);
        blink();
        chk("win2_acertos", acertos, 2'd2);

        // Button held across two positions gives a single event.
        startShow(1'b0, 2);
        botoes = 4'h1;
        step();
        chk("held_registra", db_estado, REGISTRA);
        step();
        chk("held_jogada", db_jogada, 4'h1);
        step();
        chk("held_proxima", db_estado, PROXIMA);
        step();
        step();
        chk("held_espera", db_estado, ESPERA);
        chk("held_addr1", mem_addr, 2'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_no_event", db_estado, ESPERA);
        end
        botoes = 4'h0;
        step();
        chk("released_espera", db_estado, ESPERA);
        playOk(4'h2, 1'b1);
        blink();
        chk("win3_acertos", acertos, 2'd3);

        // Fourth win saturates acertos.
        startShow(1'b0, 2);
        playOk(4'h1, 1'b0);
        playOk(4'h2, 1'b1);
        chk("win4_acertos_sat", acertos, 2'd3);
        blink();

        // Reset in the middle of MOSTRA_ON.
        nivel = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        step();
        chk("mid_show_state", db_estado, MOSTRA_ON);
        chk("mid_show_leds", leds, 4'h1);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_state", db_estado, INICIAL);
        chk("mid_rst_leds", leds, 4'h0);
        chk("mid_rst_acertos", acertos, 2'd0);
        chk("mid_rst_addr", mem_addr, 2'd0);
        chk("mid_rst_pronto", pronto, 1'b0);

        // Reset has priority over iniciar.
        iniciar = 1'b1;
        step();
        chk("rst_prio_state", db_estado, INICIAL);
        reset = 1'b0;
        iniciar = 1'b0;
        step();
        chk("post_rst_state", db_estado, INICIAL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/jogo_rodada_param.md
JOGO_RODADA_PARAM -- requirements
Module: jogo_rodada_param

Interface
REQ-001 Parameter N, 4, button/LED channel count (width of botoes, leds, mem_data).
REQ-002 Parameter DEPTH, 16, sequence memory depth; ADDR_W = clog2(DEPTH).
REQ-003 Parameter T_ON, 500, cycles a sequence LED pattern is lit.
REQ-004 Parameter T_OFF, 500, cycles LEDs are dark between patterns.
REQ-005 Parameter T_TIMEOUT, 300000, max cycles waiting for a play.
REQ-006 Parameter N_BLINK, 3, end-of-round win blinks.
REQ-007 Parameter HITS_MAX, 3, saturation value of acertos; HW = clog2(HITS_MAX+1).
REQ-008 Clock and reset: one clock; reset is synchronous and active-high.
REQ-009 clock  in  1  system clock, all state on rising edge.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 iniciar  in  1  start round (level-sampled, acted on in INICIAL or FIM_*).
REQ-012 nivel  in  1  0 = round length DEPTH/2, 1 = DEPTH; sampled on accepted iniciar.
REQ-013 botoes  in  N  raw player buttons.
REQ-014 mem_addr  out  ADDR_W  sequence ROM address.
REQ-015 mem_data  in  N  ROM data, valid 1 cycle after mem_addr changes.
REQ-016 leds  out  N  LED drive.
REQ-017 acertos  out  HW  rounds won, saturating.
REQ-018 pronto  out  1  high while in any FIM_* state.
REQ-019 ganhou  out  1  high only in FIM_ACERTO.
REQ-020 timeout  out  1  high only in FIM_TIMEOUT.
REQ-021 db_estado  out  4  current state encoding; db_jogada  out  N  last registered play.

Function
REQ-022 States: INICIAL, PREPARA, LE_MEM, MOSTRA_ON, MOSTRA_OFF, ESPERA, REGISTRA, COMPARA, PROXIMA, PISCA_ON, PISCA_OFF, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT.
REQ-023 INICIAL/FIM_* + iniciar -> PREPARA: latch nivel, mem_addr=0, clear play register, phase=show; iniciar elsewhere ignored.
REQ-024 PREPARA -> LE_MEM (1 cycle, ROM latency); in show phase LE_MEM -> MOSTRA_ON, in play phase -> ESPERA.
REQ-025 MOSTRA_ON: leds=mem_data exactly T_ON cycles, then MOSTRA_OFF: leds=0 exactly T_OFF cycles.
REQ-026 After MOSTRA_OFF: if mem_addr == last (DEPTH/2-1 or DEPTH-1 per latched nivel) set phase=play, mem_addr=0, -> LE_MEM; else mem_addr+1 -> LE_MEM.
REQ-027 ESPERA: timeout counter cleared on entry; play event = rising edge of OR(botoes); held buttons never produce a second event.
REQ-028 Play event -> REGISTRA (latch botoes into db_jogada) -> COMPARA.
REQ-029 COMPARA: correct iff registered play == mem_data on all N bits (multi-press compares as-is); wrong -> FIM_ERRO.
REQ-030 Correct, not last -> PROXIMA (mem_addr+1) -> LE_MEM; correct and last -> PISCA_ON, acertos+1 saturating at HITS_MAX.
REQ-031 PISCA_ON leds=all ones T_ON cycles, PISCA_OFF leds=0 T_OFF cycles, N_BLINK pairs, then FIM_ACERTO.
REQ-032 No play event within T_TIMEOUT cycles of ESPERA entry -> FIM_TIMEOUT; play event in the expiry cycle wins over timeout.
REQ-033 leds=0 in every state except MOSTRA_ON and PISCA_ON.
REQ-034 acertos persists across rounds; only reset clears it.

Reset
REQ-035 reset forces INICIAL, mem_addr=0, leds=0, acertos=0, db_jogada=0, pronto=ganhou=timeout=0, all timers and edge-detector history cleared, from any state including mid-show or mid-blink.
REQ-036 reset has priority over iniciar in the same cycle.

Structure
REQ-037 Package jogo_pkg holds state encoding, phase encoding and nivel constants.
REQ-038 Single reused sub-module contador_m for T_ON/T_OFF, timeout and blink counters; edge detection inline.

Verification (N=4, DEPTH=4, T_ON=T_OFF=4, T_TIMEOUT=20, N_BLINK=2, HITS_MAX=3, ROM={1,2,4,8})
REQ-039 nivel=0, iniciar, plays 1,2 -> leds show 1 then 2 (4 on/4 off each), 2 blinks of 4'hF, ganhou=1, acertos=1.
REQ-040 nivel=1, plays 1,2,8 -> FIM_ERRO at third play, pronto=1, ganhou=0, db_jogada=8, acertos unchanged.
REQ-041 nivel=0, no play after show -> timeout=1 exactly 20 cycles after ESPERA entry; edge in cycle 20 -> accepted instead.
REQ-042 botoes held at 1 through two positions -> single play event only; release and re-press 2 -> second event.
REQ-043 Four wins in a row -> acertos stays 3; reset mid-MOSTRA_ON -> next cycle INICIAL, leds=0, acertos=0.
